// File: rtl/sw_time_counter.sv
// Stopwatch time base: divides clk to a centisecond tick and accumulates min:sec:csec.
// Obeys the cnt_ctrl command from the control FSM: count, hold on pause, clear on idle.
module sw_time_counter #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cnt_ctrl,
   output logic [6:0] o_csec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic       o_tick,
   output logic       o_wrap,
   output logic       o_running
);

   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);

   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
   localparam logic [6:0]       CSEC_MAX = 7'd99;
   localparam logic [5:0]       SEC_MAX  = 6'd59;
   localparam logic [5:0]       MIN_MAX  = 6'd59;

   typedef enum logic [1:0] {
      CMD_IDLE  = 2'b00,
      CMD_COUNT = 2'b01,
      CMD_PAUSE = 2'b10
   } cmd_e;

   logic [PRE_W-1:0] pre_p0, pre_nxt;
   logic [6:0]       csec_p0, csec_nxt;
   logic [5:0]       sec_p0, sec_nxt;
   logic [5:0]       min_p0, min_nxt;
   logic             tick_p0, tick_nxt;
   logic             wrap_p0, wrap_nxt;
   logic             run_p0, run_nxt;

   // Next-state: pause holds by default; any code other than COUNT/PAUSE clears.
   always_comb begin
      pre_nxt  = pre_p0;
      csec_nxt = csec_p0;
      sec_nxt  = sec_p0;
      min_nxt  = min_p0;
      tick_nxt = 1'b0;
      wrap_nxt = 1'b0;
      run_nxt  = 1'b0;
      if (cnt_ctrl == CMD_COUNT) begin
         run_nxt = 1'b1;
         if (pre_p0 == PRE_MAX) begin
            pre_nxt  = '0;
            tick_nxt = 1'b1;
            if (csec_p0 == CSEC_MAX) begin
               csec_nxt = '0;
               if (sec_p0 == SEC_MAX) begin
                  sec_nxt = '0;
                  if (min_p0 == MIN_MAX) begin
                     min_nxt  = '0;
                     wrap_nxt = 1'b1;
                  end else begin
                     min_nxt = min_p0 + 6'd1;
                  end
               end else begin
                  sec_nxt = sec_p0 + 6'd1;
               end
            end else begin
               csec_nxt = csec_p0 + 7'd1;
            end
         end else begin
            pre_nxt = pre_p0 + PRE_W'(1);
         end
      end else if (cnt_ctrl != CMD_PAUSE) begin
         pre_nxt  = '0;
         csec_nxt = '0;
         sec_nxt  = '0;
         min_nxt  = '0;
      end
   end

   // Stage p0: registered time value and event pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_p0  <= '0;
         csec_p0 <= '0;
         sec_p0  <= '0;
         min_p0  <= '0;
         tick_p0 <= 1'b0;
         wrap_p0 <= 1'b0;
         run_p0  <= 1'b0;
      end else begin
         pre_p0  <= pre_nxt;
         csec_p0 <= csec_nxt;
         sec_p0  <= sec_nxt;
         min_p0  <= min_nxt;
         tick_p0 <= tick_nxt;
         wrap_p0 <= wrap_nxt;
         run_p0  <= run_nxt;
      end
   end

   assign o_csec    = csec_p0;
   assign o_sec     = sec_p0;
   assign o_min     = min_p0;
   assign o_tick    = tick_p0;
   assign o_wrap    = wrap_p0;
   assign o_running = run_p0;

endmodule

// File: tb/tb_sw_time_counter.sv
// Directed bench for sw_time_counter: DIV=10 instance for counting/pause/clear/reset,
// DIV=2 instance for the full 59:59.99 -> 00:00.00 wrap (preset near the end).
module tb_sw_time_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] ctrl_a = 2'b00;
   logic [1:0] ctrl_b = 2'b00;

   logic [6:0] a_csec, b_csec;
   logic [5:0] a_sec, a_min, b_sec, b_min;
   logic       a_tick, a_wrap, a_run, b_tick, b_wrap, b_run;

   int n_cmp = 0;
   int n_err = 0;
   int cnt_tick;
   int cnt_run;

   always #5 clk = ~clk;

   sw_time_counter #(.CLK_FREQ(1000), .TICK_HZ(100)) dut_a (
      .clk(clk), .rst(rst), .cnt_ctrl(ctrl_a),
      .o_csec(a_csec), .o_sec(a_sec), .o_min(a_min),
      .o_tick(a_tick), .o_wrap(a_wrap), .o_running(a_run)
   );

   sw_time_counter #(.CLK_FREQ(200), .TICK_HZ(100)) dut_b (
      .clk(clk), .rst(rst), .cnt_ctrl(ctrl_b),
      .o_csec(b_csec), .o_sec(b_sec), .o_min(b_min),
      .o_tick(b_tick), .o_wrap(b_wrap), .o_running(b_run)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int cs, input int s, input int m,
                        input int tk, input int wr, input int rn);
      check({tag, ".csec"}, 32'(a_csec), cs);
      check({tag, ".sec"},  32'(a_sec),  s);
      check({tag, ".min"},  32'(a_min),  m);
      check({tag, ".tick"}, 32'(a_tick), tk);
      check({tag, ".wrap"}, 32'(a_wrap), wr);
      check({tag, ".run"},  32'(a_run),  rn);
   endtask

   task automatic chk_b(input string tag, input int cs, input int s, input int m,
                        input int tk, input int wr);
      check({tag, ".csec"}, 32'(b_csec), cs);
      check({tag, ".sec"},  32'(b_sec),  s);
      check({tag, ".min"},  32'(b_min),  m);
      check({tag, ".tick"}, 32'(b_tick), tk);
      check({tag, ".wrap"}, 32'(b_wrap), wr);
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held across edges
      ctrl_a = 2'b01;
      step(2);
      chk_a("rst_hold", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Basic count, DIV=10
      ctrl_a = 2'b01;
      step(9);
      chk_a("cnt_e9", 0, 0, 0, 0, 0, 1);
      step(1);
      chk_a("cnt_e10", 1, 0, 0, 1, 0, 1);
      step(1);
      check("cnt_e11.tick", 32'(a_tick), 0);
      cnt_tick = 1;
      for (int i = 11; i < 1000; i++) begin
         step(1);
         if (a_tick) cnt_tick++;
      end
      chk_a("cnt_e1000", 0, 1, 0, 1, 0, 1);
      check("cnt_ticks", cnt_tick, 100);

      // Clear, then pause mid-tick
      ctrl_a = 2'b00;
      step(1);
      chk_a("clr0", 0, 0, 0, 0, 0, 0);
      ctrl_a = 2'b01;
      step(5);
      ctrl_a = 2'b10;
      cnt_tick = 0;
      cnt_run  = 0;
      for (int i = 0; i < 37; i++) begin
         step(1);
         if (a_tick) cnt_tick++;
         if (a_run) cnt_run++;
      end
      check("pause.ticks", cnt_tick, 0);
      check("pause.run", cnt_run, 0);
      check("pause.csec", 32'(a_csec), 0);
      ctrl_a = 2'b01;
      step(4);
      chk_a("resume_e9", 0, 0, 0, 0, 0, 1);
      step(1);
      chk_a("resume_e10", 1, 0, 0, 1, 0, 1);

      // Clear via 00
      ctrl_a = 2'b00;
      step(1);
      ctrl_a = 2'b01;
      step(250);
      chk_a("c250", 25, 0, 0, 1, 0, 1);
      ctrl_a = 2'b00;
      step(1);
      chk_a("idle00", 0, 0, 0, 0, 0, 0);

      // Clear via 11
      ctrl_a = 2'b01;
      step(250);
      check("c250b.csec", 32'(a_csec), 25);
      ctrl_a = 2'b11;
      step(1);
      chk_a("idle11", 0, 0, 0, 0, 0, 0);

      // PAUSE -> IDLE with a partial tick pending
      ctrl_a = 2'b01;
      step(253);
      ctrl_a = 2'b10;
      step(3);
      chk_a("p_hold", 25, 0, 0, 0, 0, 0);
      ctrl_a = 2'b00;
      step(1);
      chk_a("p2idle", 0, 0, 0, 0, 0, 0);
      ctrl_a = 2'b01;
      step(9);
      check("p2idle_e9.csec", 32'(a_csec), 0);
      step(1);
      check("p2idle_e10.csec", 32'(a_csec), 1);

      // Async reset mid-count at 0:00.07 + 3 prescaler edges
      ctrl_a = 2'b00;
      step(1);
      ctrl_a = 2'b01;
      step(73);
      check("pre_rst.csec", 32'(a_csec), 7);
      #4;
      rst = 1'b1;
      #1;
      chk_a("async_rst", 0, 0, 0, 0, 0, 0);
      step(1);
      chk_a("rst_edge", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(9);
      chk_a("post_rst_e9", 0, 0, 0, 0, 0, 1);
      step(1);
      chk_a("post_rst_e10", 1, 0, 0, 1, 0, 1);
      ctrl_a = 2'b00;

      // Full wrap, DIV=2, preset to 59:59.98 during a pause
      ctrl_b = 2'b01;
      step(1);
      chk_b("w_e1", 0, 0, 0, 0, 0);
      step(1);
      chk_b("w_e2", 1, 0, 0, 1, 0);
      ctrl_b = 2'b10;
      step(1);
      force dut_b.csec_p0 = 7'd98;
      force dut_b.sec_p0  = 6'd59;
      force dut_b.min_p0  = 6'd59;
      step(1);
      release dut_b.csec_p0;
      release dut_b.sec_p0;
      release dut_b.min_p0;
      #1;
      chk_b("w_preset", 98, 59, 59, 0, 0);
      ctrl_b = 2'b01;
      step(1);
      chk_b("w_m1", 98, 59, 59, 0, 0);
      step(1);
      chk_b("w_max", 99, 59, 59, 1, 0);
      step(1);
      chk_b("w_pre1", 99, 59, 59, 0, 0);
      step(1);
      chk_b("w_wrap", 0, 0, 0, 1, 1);
      step(1);
      chk_b("w_after", 0, 0, 0, 0, 0);
      step(1);
      chk_b("w_next", 1, 0, 0, 1, 0);
      ctrl_b = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
